// File: rtl/nubus_ad_drive_seq.sv
// nubus_ad_drive_seq: NuBus AD byte-lane enable sequencer (req_valid/req_ready/req_data/req_lanes/abort in; ad_out/lane_oe_n to bus switches; done/aborted/busy status); define NUBUS_AD_PARK_EN to park ad_out low while idle
module nubus_ad_drive_seq #(
  parameter int SETUP_CYC = 1,
  parameter int DRIVE_CYC = 2,
  parameter int GUARD_CYC = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_lanes,
  input  logic        abort,
  output logic [31:0] ad_out,
  output logic [3:0]  lane_oe_n,
  output logic        done,
  output logic        aborted,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, GUARD} state_t;
  localparam logic [3:0] SET = 4'(SETUP_CYC - 1);
  localparam logic [3:0] DRV = 4'(DRIVE_CYC - 1);
  localparam logic [3:0] GRD = GUARD_CYC == 0 ? 4'd0 : 4'(GUARD_CYC - 1);
  localparam state_t REL = GUARD_CYC == 0 ? IDLE : GUARD;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx, lanes, lanes_nx, oe_nx;
  logic [31:0] ad_nx;
  logic done_nx, aborted_nx, ready_nx;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    lanes_nx = lanes;
    ad_nx = ad_out;
    oe_nx = lane_oe_n;
    done_nx = 1'b0;
    aborted_nx = 1'b0;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        ad_nx = req_data;
        lanes_nx = req_lanes;
        cnt_nx = SET;
        state_nx = SETUP;
      end
      SETUP: if (abort) begin
        oe_nx = 4'hF;
        aborted_nx = 1'b1;
        cnt_nx = GRD;
        state_nx = REL;
      end else if (cnt == 4'd0) begin
        oe_nx = ~lanes;
        cnt_nx = DRV;
        state_nx = DRIVE;
      end else cnt_nx = cnt - 4'd1;
      DRIVE: if (abort || cnt == 4'd0) begin
        oe_nx = 4'hF;
        aborted_nx = abort;
        done_nx = !abort;
        cnt_nx = GRD;
        state_nx = REL;
      end else cnt_nx = cnt - 4'd1;
      default: if (cnt == 4'd0) state_nx = IDLE;
        else cnt_nx = cnt - 4'd1;
    endcase
`ifdef NUBUS_AD_PARK_EN
    ad_nx = (state_nx == IDLE && (state == DRIVE || state == GUARD)) ? 32'd0 : ad_nx;
`endif
    ready_nx = state_nx == IDLE && !abort;
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      lanes <= 4'd0;
      ad_out <= 32'd0;
      lane_oe_n <= 4'hF;
      done <= 1'b0;
      aborted <= 1'b0;
      req_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      lanes <= lanes_nx;
      ad_out <= ad_nx;
      lane_oe_n <= oe_nx;
      done <= done_nx;
      aborted <= aborted_nx;
      req_ready <= ready_nx;
      busy <= state_nx != IDLE;
    end
endmodule

// File: tb/tb_nubus_ad_drive_seq.sv
// tb_nubus_ad_drive_seq: directed self-checking bench for nubus_ad_drive_seq
module tb_nubus_ad_drive_seq;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic req_valid = 1'b0, abort = 1'b0, v2 = 1'b0;
  logic [31:0] req_data = 32'd0;
  logic [3:0] req_lanes = 4'd0;
  logic req_ready, done, aborted, busy;
  logic [31:0] ad_out;
  logic [3:0] lane_oe_n;
  logic r0, d0, a0, bz0, r3, d3, a3, bz3;
  logic [31:0] ad0, ad3;
  logic [3:0] oe0, oe3;
  int vectors = 0, errs = 0;
  int t0[2] = '{-100, -100};
  int t3[2] = '{-100, -100};
  int n0 = 0, n3 = 0;
  logic [31:0] idle_ad;
  always #5 sys_clk = ~sys_clk;
  nubus_ad_drive_seq dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_lanes(req_lanes), .abort(abort), .ad_out(ad_out), .lane_oe_n(lane_oe_n),
    .done(done), .aborted(aborted), .busy(busy));
  nubus_ad_drive_seq #(.GUARD_CYC(0)) b0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(v2), .req_ready(r0),
    .req_data(32'hA5A5A5A5), .req_lanes(4'hF), .abort(1'b0), .ad_out(ad0), .lane_oe_n(oe0),
    .done(d0), .aborted(a0), .busy(bz0));
  nubus_ad_drive_seq #(.GUARD_CYC(3)) b3 (.sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(v2), .req_ready(r3),
    .req_data(32'h5A5A5A5A), .req_lanes(4'hF), .abort(1'b0), .ad_out(ad3), .lane_oe_n(oe3),
    .done(d3), .aborted(a3), .busy(bz3));
  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
`ifdef NUBUS_AD_PARK_EN
    idle_ad = 32'd0;
`else
    idle_ad = 32'hDEADBEEF;
`endif
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_ad", ad_out, 0);
    chk("rst_oe", lane_oe_n, 4'hF);
    chk("rst_flags", {done, aborted, busy}, 0);
    sys_rst = 1'b0;
    step;
    chk("ready_after_rst", req_ready, 1);
    req_valid = 1'b1; req_data = 32'hDEADBEEF; req_lanes = 4'hF;
    step;
    req_valid = 1'b0;
    chk("t1_ad_T", ad_out, 32'hDEADBEEF);
    chk("t1_oe_T", lane_oe_n, 4'hF);
    chk("t1_busy_ready_T", {busy, req_ready}, 2'b10);
    step;
    chk("t1_oe_T1", lane_oe_n, 4'h0);
    step;
    chk("t1_oe_T2", lane_oe_n, 4'h0);
    chk("t1_ad_T2", ad_out, 32'hDEADBEEF);
    chk("t1_done_T2", done, 0);
    step;
    chk("t1_oe_T3", lane_oe_n, 4'hF);
    chk("t1_done_T3", done, 1);
    chk("t1_ready_T3", req_ready, 0);
    step;
    chk("t1_done_T4", done, 0);
    chk("t1_ready_T4", {req_ready, busy}, 2'b10);
    chk("t1_idle_ad", ad_out, idle_ad);
    req_valid = 1'b1; req_data = 32'h12345678; req_lanes = 4'b0101;
    step;
    req_valid = 1'b0;
    chk("t2_oe_T", lane_oe_n, 4'hF);
    step;
    chk("t2_oe_T1", lane_oe_n, 4'b1010);
    step;
    chk("t2_oe_T2", lane_oe_n, 4'b1010);
    step;
    chk("t2_oe_done_T3", {lane_oe_n, done}, 5'b11111);
    step;
    chk("t2_ready_T4", req_ready, 1);
    req_valid = 1'b1; req_data = 32'h0F0F0F0F; req_lanes = 4'b0000;
    step;
    req_valid = 1'b0;
    chk("t3_ad_T", ad_out, 32'h0F0F0F0F);
    step;
    chk("t3_oe_T1", lane_oe_n, 4'hF);
    step;
    chk("t3_oe_T2", lane_oe_n, 4'hF);
    step;
    chk("t3_oe_done_T3", {lane_oe_n, done}, 5'b11111);
    step;
    chk("t3_ready_T4", req_ready, 1);
    req_valid = 1'b1; req_data = 32'hCAFEF00D; req_lanes = 4'hF;
    step;
    req_valid = 1'b0;
    step;
    chk("t4_oe_drive", lane_oe_n, 4'h0);
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("t4_oe_abort", lane_oe_n, 4'hF);
    chk("t4_aborted", aborted, 1);
    chk("t4_no_done", done, 0);
    chk("t4_ready_guard", req_ready, 0);
    step;
    chk("t4_aborted_pulse", {aborted, done}, 2'b00);
    chk("t4_ready_back", req_ready, 1);
    abort = 1'b1;
    step;
    chk("idle_abort_mask", req_ready, 0);
    abort = 1'b0;
    step;
    chk("idle_abort_unmask", req_ready, 1);
    req_valid = 1'b1; req_data = 32'h87654321; req_lanes = 4'hF;
    step;
    req_valid = 1'b0;
    chk("t5_setup_busy", busy, 1);
    #3 sys_rst = 1'b1;
    #1;
    chk("t5_rst_oe", lane_oe_n, 4'hF);
    chk("t5_rst_ad", ad_out, 0);
    chk("t5_rst_ready_busy", {req_ready, busy}, 0);
    sys_rst = 1'b0;
    #1;
    chk("t5_ready_before_edge", req_ready, 0);
    step;
    chk("t5_ready_after_edge", req_ready, 1);
    chk("t5_no_pulse", {done, aborted}, 0);
    v2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (r0 && n0 < 2) begin t0[n0] = i; n0++; end
      if (r3 && n3 < 2) begin t3[n3] = i; n3++; end
      step;
    end
    v2 = 1'b0;
    chk("b2b_g0_spacing", t0[1] - t0[0], 4);
    chk("b2b_g3_spacing", t3[1] - t3[0], 7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/nubus_ad_drive_seq.md
# nubus_ad_drive_seq

Output-enable sequencer for the four 8-bit bus switches that drive the NuBus AD[31:0] lines. It accepts one 32-bit word plus a byte-lane mask through a valid/ready handshake. It registers the word onto the switch B-side, and only then lowers the per-lane active-low enables. It holds the drive for a programmed number of cycles, then releases and enforces a turnaround guard before the next word. It sits directly upstream of the switches: each `lane_oe_n[i]` and `ad_out[8i+7:8i]` feed one switch instance.

## Interface
Parameters:
- `SETUP_CYC`, 1: cycles data is stable on `ad_out` with enables high before drive; range 1..15.
- `DRIVE_CYC`, 2: cycles enables are held low; range 1..15.
- `GUARD_CYC`, 1: turnaround cycles with enables high after drive; range 0..15.

Ports:
- `sys_clk` in 1: single clock; all logic is rising-edge.
- `sys_rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: a word is offered.
- `req_ready` out 1: the sequencer can accept a word.
- `req_data` in 32: word to drive.
- `req_lanes` in 4: bit i enables byte lane i.
- `abort` in 1: force release (e.g. bus reset or lost arbitration).
- `ad_out` out 32: switch B-side data.
- `lane_oe_n` out 4: switch enables, active-low.
- `done` out 1: one-cycle pulse on normal drive completion.
- `aborted` out 1: one-cycle pulse when a drive is cut short by `abort`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Clocking and reset: one clock (`sys_clk`); `sys_rst` is asynchronous, active-high.
- Reset values: state=IDLE, `req_ready`=0, `ad_out`=0, `lane_oe_n`=4'hF, `done`=0, `aborted`=0, `busy`=0, counter=0.
- All outputs are registered.
- The FSM has four states: IDLE, SETUP, DRIVE, GUARD.
- IDLE:
  - `req_ready`=1 unless `abort`=1 in that cycle.
  - Handshake fires when `req_valid`&`req_ready`.
  - On the handshake, `ad_out`<=`req_data`, the lane mask is latched, counter<=SETUP_CYC-1, and the FSM moves to SETUP.
- SETUP:
  - `lane_oe_n`=4'hF.
  - Counts down; at 0, `lane_oe_n`<=~lanes, counter<=DRIVE_CYC-1, next state DRIVE.
- DRIVE:
  - `lane_oe_n`=~lanes and `ad_out` is frozen.
  - Counts down; at 0, `lane_oe_n`<=4'hF and `done` pulses.
  - Next state is GUARD with counter<=GUARD_CYC-1, or IDLE if GUARD_CYC=0.
- GUARD:
  - `lane_oe_n`=4'hF.
  - Counts down; at 0, next state is IDLE.
- `abort` in SETUP or DRIVE:
  - Next edge: `lane_oe_n`<=4'hF and `aborted` pulses.
  - The FSM enters GUARD, or IDLE if GUARD_CYC=0.
  - `done` is not pulsed.
- `abort` in GUARD or IDLE: no state change; in IDLE it only masks `req_ready`.
- `req_lanes`=0: the word is accepted and full timing runs, but `lane_oe_n` stays 4'hF; `done` still pulses.
- `ad_out` never changes while any `lane_oe_n` bit is low.

## Timing
- Handshake at edge T:
  - `ad_out` is valid from T.
  - `lane_oe_n` goes low at T+SETUP_CYC and returns high at T+SETUP_CYC+DRIVE_CYC.
  - `done` is high during the cycle after T+SETUP_CYC+DRIVE_CYC.
  - `req_ready` is high again at T+SETUP_CYC+DRIVE_CYC+GUARD_CYC (+0 extra cycles if GUARD_CYC=0).
- Minimum spacing between accepted words is SETUP_CYC+DRIVE_CYC+GUARD_CYC+1 cycles.
- `req_ready` rises at the first edge after `sys_rst` deasserts.
- `sys_rst` mid-drive: `lane_oe_n` goes 4'hF asynchronously, with no `done` or `aborted` pulse.

## Configuration
- `NUBUS_AD_PARK_EN`:
  - Defined: `ad_out` is cleared to 0 on the edge that enters IDLE from DRIVE or GUARD, so the switch B-side is parked low while idle.
  - Undefined: `ad_out` retains the last driven word until the next handshake.

## Test plan
- Reset release, defaults: `req_data`=32'hDEADBEEF, `req_lanes`=4'hF -> `ad_out`=DEADBEEF at T, `lane_oe_n`=0 for cycles T+1..T+2, `done` at T+3, `req_ready` at T+4.
- Byte lanes: `req_lanes`=4'b0101 -> `lane_oe_n`=4'b1010 during DRIVE only; `req_lanes`=0 -> `lane_oe_n` is never low and `done` still pulses.
- Abort in the first DRIVE cycle -> `lane_oe_n`=4'hF next edge, `aborted`=1 for one cycle, `done`=0, `req_ready` returns after GUARD_CYC.
- Back-to-back requests with `req_valid` held high and GUARD_CYC=0 -> second handshake exactly 4 cycles after the first; GUARD_CYC=3 -> 7 cycles.
- Async `sys_rst` pulse mid-SETUP (between clock edges) -> `lane_oe_n`=4'hF and `ad_out`=0 immediately; `req_ready`=0 until the first edge after release.
- `NUBUS_AD_PARK_EN`:
  - Defined: `ad_out`=0 once IDLE is re-entered.
  - Undefined: `ad_out` holds DEADBEEF in IDLE.
